priority_encoder_drain: RTL and testbench

//  Parametrised, clocked successor to the 4-input combinational priority encoder.

---
 rtl/penc_pkg.sv | 17 +
 rtl/penc_core.sv | 31 +++
 rtl/priority_encoder_drain.sv | 117 +++++++++++
 tb/tb_priority_encoder_drain.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/penc_pkg.sv
// Shared types and helpers for the draining priority encoder.
//   state_e    : FSM encoding (IDLE accepts a vector, DRAIN emits its beats)
//   clog2_min1 : ceil(log2(n)) clamped to at least 1, for safe port widths
package penc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/penc_core.sv
// Combinational priority core used on the pending register.
// Ports:
//   vec    in   N    vector to encode; bit N-1 has highest priority
//   idx    out  IW   index of the highest set bit (0 when vec is zero)
//   any    out  1    at least one bit set
//   onehot out  1    exactly one bit set
module penc_core
  import penc_pkg::*;
#(
  parameter int unsigned N  = 8,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          onehot
);

  always_comb begin
    idx = '0;
    // Ascending scan: the last hit wins, leaving the highest set bit.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = i[IW-1:0];
    end
  end

  assign any    = |vec;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign onehot = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/priority_encoder_drain.sv
// Clocked priority encoder: accepts an N-bit request vector via valid/ready,
// then emits the index of every set bit, highest first, one per output beat.
// An all-zero vector yields a single beat flagged with out_zero.
// Optional feature macro: PENC_COUNT_EN adds out_cnt (bits still pending).
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    request vector valid
//   in_ready   out  1    high only in IDLE
//   in_req     in   N    request vector
//   out_valid  out  1    beat valid (DRAIN)
//   out_ready  in   1    consumer accepts current beat
//   out_idx    out  IW   highest pending index
//   out_last   out  1    final beat of this vector
//   out_zero   out  1    accepted vector was all-zero
//   out_cnt    out  CW   pending popcount incl. current beat (PENC_COUNT_EN)
module priority_encoder_drain
  import penc_pkg::*;
#(
  parameter int unsigned N  = 8,
  localparam int unsigned IW = clog2_min1(N),
  localparam int unsigned CW = clog2_min1(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
`ifdef PENC_COUNT_EN
  output logic [CW-1:0] out_cnt,
`endif
  output logic          out_zero
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] clr_mask;
  logic [IW-1:0] hi_idx;
  logic         pend_any, pend_onehot;
  logic         in_drain, xfer;

  penc_core #(
    .N(N)
  ) u_core (
    .vec    (pending_q),
    .idx    (hi_idx),
    .any    (pend_any),
    .onehot (pend_onehot)
  );

  assign in_drain  = (state_q == DRAIN);
  assign in_ready  = !in_drain;
  assign out_valid = in_drain;
  // Pending is cleared on every return to IDLE, so hi_idx is already 0 there.
  assign out_idx   = hi_idx;
  // A zero vector in DRAIN is its own (single, final) beat.
  assign out_zero  = in_drain && !pend_any;
  assign out_last  = in_drain && (pend_onehot || !pend_any);
  assign xfer      = out_valid && out_ready;

  always_comb begin
    clr_mask         = '0;
    clr_mask[hi_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        // in_req is only sampled under in_valid, keeping X/Z out of state.
        if (in_valid) begin
          pending_d = in_req;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (out_last) begin
            pending_d = '0;
            state_d   = IDLE;
          end else begin
            pending_d = pending_q & ~clr_mask;
          end
        end
      end
      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef PENC_COUNT_EN
  always_comb begin
    out_cnt = '0;
    for (int i = 0; i < N; i++) begin
      out_cnt = out_cnt + CW'(pending_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_priority_encoder_drain.sv
// Directed bench for priority_encoder_drain at N=8. Inputs change on the
// falling edge; outputs are checked on the falling edge (or #1 after reset).
module tb_priority_encoder_drain;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_req;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_zero;
`ifdef PENC_COUNT_EN
  logic [CW-1:0] out_cnt;
`endif

  int checks;
  int errors;

  priority_encoder_drain #(
    .N(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
`ifdef PENC_COUNT_EN
    .out_cnt   (out_cnt),
`endif
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full beat: valid, ready, idx, last, zero.
  task automatic chk_beat(input string tag, input logic v, input logic [IW-1:0] idx,
                          input logic last, input logic zero);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".ready"}, 32'(in_ready), 32'(!v));
    chk({tag, ".idx"},   32'(out_idx), 32'(idx));
    chk({tag, ".last"},  32'(out_last), 32'(last));
    chk({tag, ".zero"},  32'(out_zero), 32'(zero));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_req    = 'x;
    out_ready = 1'b0;

    // 1. reset state
    @(negedge clk);
    chk_beat("reset", 1'b0, 3'd0, 1'b0, 1'b0);
`ifdef PENC_COUNT_EN
    chk("reset.cnt", 32'(out_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk_beat("idle_x", 1'b0, 3'd0, 1'b0, 1'b0);

    // 2. 1010_0100 -> 7, 5, 2
    in_req = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_req = 'x;
    chk_beat("a4.b0", 1'b1, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("a4.b1", 1'b1, 3'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("a4.b2", 1'b1, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk_beat("a4.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // 3. all-zero vector
    in_req = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("zero.b0", 1'b1, 3'd0, 1'b1, 1'b1);
`ifdef PENC_COUNT_EN
    chk("zero.cnt", 32'(out_cnt), 32'd0);
`endif
    @(negedge clk);
    chk_beat("zero.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // 4. 0x81 with 3 cycles of backpressure; in_valid held with other data
    in_req = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_req = 8'h3C;
    chk_beat("bp.c0", 1'b1, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("bp.c1", 1'b1, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("bp.c2", 1'b1, 3'd7, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("bp.b1", 1'b1, 3'd0, 1'b1, 1'b0);
    in_valid = 1'b0; in_req = 'x;
    @(negedge clk);
    chk_beat("bp.idle", 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("bp.idle2", 1'b0, 3'd0, 1'b0, 1'b0);

    // 5. 0xFF, reset after 3 beats, then 0x10
    in_req = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_req = 'x;
    chk_beat("ff.b0", 1'b1, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("ff.b1", 1'b1, 3'd6, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("ff.b2", 1'b1, 3'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk_beat("ff.b3", 1'b1, 3'd4, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_beat("ff.rst", 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_req = 8'h10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_req = 'x;
    chk_beat("h10.b0", 1'b1, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk_beat("h10.idle", 1'b0, 3'd0, 1'b0, 1'b0);

`ifdef PENC_COUNT_EN
    // 6. popcount 0x0F -> 4,3,2,1
    in_req = 8'h0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_req = 'x;
    for (int k = 0; k < 4; k++) begin
      chk_beat($sformatf("cnt.b%0d", k), 1'b1, 3'(3 - k), (k == 3), 1'b0);
      chk($sformatf("cnt.v%0d", k), 32'(out_cnt), 32'(4 - k));
      @(negedge clk);
    end
    chk("cnt.idle", 32'(out_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
